// File: rtl/inst_sram_like_to_axi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// inst_sram_like_to_axi
//
// Purpose:
//   Turns each dual-instruction SRAM-like read request into one AXI4 read
//   burst (INCR, 4 bytes per beat). Normally two beats are fetched, and both
//   words are returned together with inst_data_ok1/inst_data_ok2 in the same
//   cycle. If the second word would fall in the next 4 KB page, only one beat
//   is requested and only inst_data_ok1 is raised. The block is read-only.
//   At most one transaction is outstanding.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   inst_req/wr/size/addr  SRAM-like request (wr and size are ignored)
//   inst_addr_ok           request accepted (AR handshake cycle)
//   inst_data_ok1/2        word 1 / word 2 valid (single-cycle pulses)
//   inst_rdata1/2          instruction at inst_addr / inst_addr+4
//   ar*                    AXI read address channel (master side)
//   r*                     AXI read data channel (master side)
//   inst_bus_err           only with INST_AXI_RRESP_CHECK_EN: some beat of
//                          this transaction returned an error response;
//                          valid together with inst_data_ok1
//
// Optional feature macro: INST_AXI_RRESP_CHECK_EN
// ---------------------------------------------------------------------------
module inst_sram_like_to_axi #(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [31:0]     inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok1,
  output logic            inst_data_ok2,
  output logic [31:0]     inst_rdata1,
  output logic [31:0]     inst_rdata2,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
`ifdef INST_AXI_RRESP_CHECK_EN
  ,
  output logic            inst_bus_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R0   = 2'd2,
    ST_R1   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_araddr;
  logic        r_single;   // request sits in the last word of a 4 KB page
  logic [31:0] r_beat0;
  logic        r_arvalid;
  logic        r_rready;

  logic w_beat;            // an R beat is accepted this cycle
  logic w_ok_single;       // final (and only) beat of a single-beat read
  logic w_ok_pair;         // second beat of a two-beat read

  // Interface signals this block deliberately does not look at: the
  // instruction side never writes and always asks for words, and beat
  // counting is done by state rather than by rlast/rid.
  logic w_unused_ok;
  assign w_unused_ok = ^{inst_wr, inst_size, rid, rlast, rresp};

  assign w_beat      = rvalid & r_rready;
  assign w_ok_single = w_beat & (r_state == ST_R0) & r_single;
  assign w_ok_pair   = w_beat & (r_state == ST_R1);

  // AR channel
  assign arid    = ID_W'(AXI_ID);
  assign araddr  = r_araddr;
  assign arlen   = r_single ? 8'd0 : 8'd1;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  // SRAM-like side. addr_ok is the AR handshake itself, so it can never
  // coincide with data_ok (R beats are only accepted in later states).
  assign inst_addr_ok  = r_arvalid & arready;
  assign inst_data_ok1 = w_ok_single | w_ok_pair;
  assign inst_data_ok2 = w_ok_pair;

  // Word 1 comes straight from the bus on a single-beat read, otherwise
  // from the saved first beat. Both words read as zero when idle.
  always_comb begin
    inst_rdata1 = 32'd0;
    inst_rdata2 = 32'd0;
    if (w_ok_single) begin
      inst_rdata1 = rdata;
    end else if (r_state == ST_R1) begin
      inst_rdata1 = r_beat0;
    end
    if (w_ok_pair) begin
      inst_rdata2 = rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_araddr  <= 32'd0;
      r_single  <= 1'b0;
      r_beat0   <= 32'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_req) begin
            r_araddr  <= inst_addr;
            // A 2-beat burst from the page's last word would cross 4 KB.
            r_single  <= (inst_addr[11:2] == 10'h3FF);
            r_arvalid <= 1'b1;
            r_state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R0;
          end
        end
        ST_R0: begin
          if (rvalid) begin
            if (r_single) begin
              r_rready <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_beat0  <= rdata;
              r_state  <= ST_R1;
            end
          end
        end
        ST_R1: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_AXI_RRESP_CHECK_EN
  // Sticky error for the transaction in flight; the final beat's own
  // response is folded in combinationally so it is reported with data_ok1.
  logic r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_err <= 1'b0;
    end else if (w_beat && rresp[1]) begin
      r_err <= 1'b1;
    end
  end

  assign inst_bus_err = inst_data_ok1 & (r_err | rresp[1]);
`endif

endmodule

// File: tb/tb_inst_sram_like_to_axi.sv
`timescale 1ns/1ps
module tb_inst_sram_like_to_axi;

  localparam int ID_W   = 4;
  localparam int AXI_ID = 5;

  logic            clk;
  logic            resetn;
  logic            inst_req;
  logic            inst_wr;
  logic [1:0]      inst_size;
  logic [31:0]     inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok1;
  logic            inst_data_ok2;
  logic [31:0]     inst_rdata1;
  logic [31:0]     inst_rdata2;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
`ifdef INST_AXI_RRESP_CHECK_EN
  logic            inst_bus_err;
`endif

  int checks = 0;
  int errors = 0;

  inst_sram_like_to_axi #(.ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok1(inst_data_ok1),
    .inst_data_ok2(inst_data_ok2),
    .inst_rdata1  (inst_rdata1),
    .inst_rdata2  (inst_rdata2),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
`ifdef INST_AXI_RRESP_CHECK_EN
    ,
    .inst_bus_err (inst_bus_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a 2-word fetch from a word address stays in one 4 KB page
  // unless its 8 bytes run past the page end.
  function automatic bit crosses_page(input logic [31:0] addr);
    return ((addr % 32'd4096) + 32'd8) > 32'd4096;
  endfunction

  // One complete request as seen from both sides. The bench plays the AXI
  // slave: it holds arready low for ar_dly cycles, inserts gap idle cycles
  // before each beat, and returns d0/d1 with responses rr0/rr1.
  task automatic do_txn(input logic [31:0] addr, input int ar_dly, input int gap,
                        input bit hold, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] rr0, input logic [1:0] rr1);
    bit          single;
    int          nb;
    logic [31:0] beats [2];
    logic [1:0]  rrs   [2];
    logic [31:0] exp_len;
    logic [31:0] exp_w2;
    bit          exp_err;
    single   = crosses_page(addr);
    nb       = single ? 1 : 2;
    beats[0] = d0;
    beats[1] = d1;
    rrs[0]   = rr0;
    rrs[1]   = rr1;
    exp_len  = single ? 32'd0 : 32'd1;
    exp_w2   = single ? 32'd0 : d1;
    exp_err  = rr0[1] | (!single & rr1[1]);

    // Request cycle (DUT idle)
    inst_req  = 1'b1;
    inst_addr = addr;
    @(negedge clk);
    chk("idle_arvalid", arvalid, 0);
    chk("idle_addr_ok", inst_addr_ok, 0);
    chk("idle_data_ok1", inst_data_ok1, 0);
    @(posedge clk); #1;
    inst_req = hold;
    if (hold) inst_addr = $urandom;   // must not be re-latched while busy

    // AR backpressure
    for (int i = 0; i < ar_dly; i++) begin
      arready = 1'b0;
      @(negedge clk);
      chk("ar_wait_arvalid", arvalid, 1);
      chk("ar_wait_araddr", araddr, addr);
      chk("ar_wait_arlen", arlen, exp_len);
      chk("ar_wait_addr_ok", inst_addr_ok, 0);
      chk("ar_wait_rready", rready, 0);
      @(posedge clk); #1;
    end

    // AR handshake
    arready = 1'b1;
    @(negedge clk);
    chk("ar_arvalid", arvalid, 1);
    chk("ar_addr_ok", inst_addr_ok, 1);
    chk("ar_araddr", araddr, addr);
    chk("ar_arlen", arlen, exp_len);
    chk("ar_arsize", arsize, 3'b010);
    chk("ar_arburst", arburst, 2'b01);
    chk("ar_arid", arid, AXI_ID);
    chk("ar_rready", rready, 0);
    chk("ar_data_ok1", inst_data_ok1, 0);
    @(posedge clk); #1;
    arready = 1'b0;

    // R beats
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        rdata  = $urandom;
        @(negedge clk);
        chk("r_gap_rready", rready, 1);
        chk("r_gap_arvalid", arvalid, 0);
        chk("r_gap_data_ok1", inst_data_ok1, 0);
        chk("r_gap_data_ok2", inst_data_ok2, 0);
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = beats[b];
      rresp  = rrs[b];
      rid    = ID_W'($urandom);
      rlast  = (b == nb - 1);
      @(negedge clk);
      chk("r_rready", rready, 1);
      chk("r_addr_ok", inst_addr_ok, 0);
      if (b == nb - 1) begin
        chk("r_data_ok1", inst_data_ok1, 1);
        chk("r_data_ok2", inst_data_ok2, single ? 0 : 1);
        chk("r_rdata1", inst_rdata1, d0);
        chk("r_rdata2", inst_rdata2, exp_w2);
`ifdef INST_AXI_RRESP_CHECK_EN
        chk("r_bus_err", inst_bus_err, exp_err);
`endif
      end else begin
        chk("r_beat0_data_ok1", inst_data_ok1, 0);
        chk("r_beat0_data_ok2", inst_data_ok2, 0);
      end
      @(posedge clk); #1;
      rvalid = 1'b0;
      rresp  = 2'b00;
      rlast  = 1'b0;
    end
    $display("txn addr=%h single=%0d ar_dly=%0d gap=%0d hold=%0d w1=%h w2=%h err=%0d",
             addr, single, ar_dly, gap, hold, d0, exp_w2, exp_err);
  endtask

  initial begin
    logic [31:0] a;
    bit          h;
    resetn    = 1'b0;
    inst_req  = 1'b0;
    inst_wr   = 1'b0;
    inst_size = 2'b10;
    inst_addr = 32'd0;
    arready   = 1'b0;
    rid       = '0;
    rdata     = 32'd0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    // Reset state
    #12;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_ok1", inst_data_ok1, 0);
    chk("rst_data_ok2", inst_data_ok2, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rdata1", inst_rdata1, 0);
    chk("rst_rdata2", inst_rdata2, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic burst
    do_txn(32'hBFC0_0000, 0, 0, 0, 32'h2408_0001, 32'h2409_0002, 2'b00, 2'b00);
    // AR backpressure
    do_txn(32'h1FC0_0120, 5, 0, 0, $urandom, $urandom, 2'b00, 2'b00);
    // 4 KB edge
    do_txn(32'h0000_0FFC, 0, 0, 0, 32'h0000_1234, $urandom, 2'b00, 2'b00);
    // R gaps with req held high, then back-to-back request
    do_txn(32'h8000_1000, 0, 3, 1, $urandom, $urandom, 2'b00, 2'b00);
    do_txn(32'h8000_2008, 1, 3, 0, $urandom, $urandom, 2'b00, 2'b00);

    // Reset in the middle of a burst (after beat0)
    inst_req  = 1'b1;
    inst_addr = 32'h0040_0010;
    @(posedge clk); #1;
    inst_req = 1'b0;
    arready  = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_data_ok1", inst_data_ok1, 0);
    chk("mid_rst_data_ok2", inst_data_ok2, 0);
    chk("mid_rst_rdata1", inst_rdata1, 0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_txn(32'h0040_0FFC, 0, 0, 0, 32'h1357_9BDF, $urandom, 2'b00, 2'b00);
    do_txn(32'h0040_0010, 0, 1, 0, 32'h0BAD_F00D, 32'hCAFE_0001, 2'b00, 2'b00);

    // Error responses (reported only when the checker is built in)
    do_txn(32'h0000_2000, 0, 0, 0, $urandom, $urandom, 2'b00, 2'b10);
    do_txn(32'h0000_2008, 0, 0, 0, $urandom, $urandom, 2'b00, 2'b00);
    do_txn(32'h0000_3FFC, 0, 0, 0, $urandom, $urandom, 2'b11, 2'b00);
    do_txn(32'h0000_2010, 0, 2, 0, $urandom, $urandom, 2'b10, 2'b01);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      a = a & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0FFC;
      h = (i < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
      do_txn(a, $urandom_range(0, 3), $urandom_range(0, 3), h,
             $urandom, $urandom, 2'($urandom), 2'($urandom));
    end

    @(negedge clk);
    chk("end_idle_arvalid", arvalid, 0);
    chk("end_idle_rready", rready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
